// File: rtl/ro_mux_param.sv
// rtl/ro_mux_param.sv - time-multiplexed readout of NCH channel words onto a W-bit bus
//
// Purpose:
//   Each rising edge of clk_32 (sampled as data on clk_ext) requests one frame.
//   A frame snapshots in_bus and presents channel 0..NCH-1 on out, one channel
//   per slot, each slot SLOT_CYC cycles long. out_en replaces per-bit tristates.
//
// Optional feature:
//   RO_PARITY_EN - when defined, out_par carries the XOR of out during a frame;
//                  when undefined, out_par is tied to 0 and no parity is built.
//
// Ports:
//   clk_ext     in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   clk_32      in   divided frame clock, sampled as data
//   en          in   readout enable, gates new requests only
//   in_bus      in   NCH*W channel words, channel k at [k*W +: W]
//   clr_ovf     in   clears the sticky overrun flag
//   out         out  current slot word, 0 when not driving
//   out_en      out  bus drive enable
//   ch_idx      out  channel currently driven
//   frame_done  out  one-cycle pulse after the last slot
//   ovf         out  sticky overrun flag
//   out_par     out  slot parity (see RO_PARITY_EN)

module ro_mux_param #(
    parameter int NCH      = 8,
    parameter int W        = 2,
    parameter int SLOT_CYC = 4
) (
    input  logic                   clk_ext,
    input  logic                   rst,
    input  logic                   clk_32,
    input  logic                   en,
    input  logic [NCH*W-1:0]       in_bus,
    input  logic                   clr_ovf,
    output logic [W-1:0]           out,
    output logic                   out_en,
    output logic [$clog2(NCH)-1:0] ch_idx,
    output logic                   frame_done,
    output logic                   ovf,
    output logic                   out_par
);

    localparam int IW = $clog2(NCH);
    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    nxt_cnt;
    logic [IW-1:0]    nxt_idx;
    logic [NCH*W-1:0] shadow;
    logic [NCH*W-1:0] nxt_shadow;
    logic             clk_32_q;
    logic             req;
    logic             overrun;
    logic             nxt_done;
    logic [W-1:0]     nxt_word;
    logic             nxt_drive;

    // A request is a 0->1 transition of clk_32 between two clk_ext edges.
    assign req = clk_32 & ~clk_32_q;

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_idx    = ch_idx;
        nxt_shadow = shadow;
        nxt_done   = 1'b0;
        overrun    = 1'b0;

        case (state)
            IDLE: begin
                if (req && en) begin
                    nxt_state  = SHIFT;
                    nxt_shadow = in_bus;
                    nxt_idx    = '0;
                    nxt_cnt    = '0;
                end
            end
            SHIFT: begin
                // Any enabled request while a frame is in flight, including on
                // the final slot edge, is dropped and flagged.
                overrun = req && en;
                if (cnt == LAST_CNT) begin
                    nxt_cnt = '0;
                    if (ch_idx == LAST_IDX) begin
                        nxt_state = IDLE;
                        nxt_idx   = '0;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_idx = ch_idx + 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_idx   = '0;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so the bus word lines up
    // with ch_idx in the same cycle, starting the cycle after the request edge.
    assign nxt_drive = (nxt_state == SHIFT);
    assign nxt_word  = nxt_drive ? nxt_shadow[int'(nxt_idx)*W +: W] : '0;

    always_ff @(posedge clk_ext) begin
        // Loaded during reset too, so a level already high at release is not
        // mistaken for a rising edge.
        clk_32_q <= clk_32;
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ch_idx     <= '0;
            shadow     <= '0;
            out        <= '0;
            out_en     <= 1'b0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            ch_idx     <= nxt_idx;
            shadow     <= nxt_shadow;
            out        <= nxt_word;
            out_en     <= nxt_drive;
            frame_done <= nxt_done;
            if (overrun) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef RO_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_ext) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= nxt_drive ? ^nxt_word : 1'b0;
        end
    end

    assign out_par = par_q;
`else
    assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_ro_mux_param.sv
// tb/tb_ro_mux_param.sv - directed self-checking bench for ro_mux_param

module tb_ro_mux_param;

    localparam int NCH      = 8;
    localparam int W        = 2;
    localparam int SLOT_CYC = 4;
    localparam int FRAME    = NCH * SLOT_CYC;

    logic              clk_ext = 1'b0;
    logic              rst;
    logic              clk_32;
    logic              en;
    logic [NCH*W-1:0]  in_bus;
    logic              clr_ovf;
    logic [W-1:0]      out;
    logic              out_en;
    logic [2:0]        ch_idx;
    logic              frame_done;
    logic              ovf;
    logic              out_par;

    int checks = 0;
    int errors = 0;

    logic [15:0] snap;

    ro_mux_param #(.NCH(NCH), .W(W), .SLOT_CYC(SLOT_CYC)) dut (
        .clk_ext    (clk_ext),
        .rst        (rst),
        .clk_32     (clk_32),
        .en         (en),
        .in_bus     (in_bus),
        .clr_ovf    (clr_ovf),
        .out        (out),
        .out_en     (out_en),
        .ch_idx     (ch_idx),
        .frame_done (frame_done),
        .ovf        (ovf),
        .out_par    (out_par)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic tick();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_32 = 1'b0; en = 1'b1; in_bus = '0; clr_ovf = 1'b0;
        repeat (3) tick();
        checks++;
        if ({out, out_en, ch_idx, frame_done, ovf, out_par} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {out, out_en, ch_idx, frame_done, ovf, out_par});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: out_en got %b want 0", out_en);
        end
    endtask

    // Full frame from 16'hE4E4: words 0,1,2,3,0,1,2,3, each held SLOT_CYC cycles.
    task automatic test_frame();
        int fd;
        logic [1:0] ew;
        logic       ep;
        fd = 0;
        snap = 16'hE4E4;
        in_bus = snap;
        clk_32 = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            clk_32 = 1'b0;
            ew = snap[(i/SLOT_CYC)*2 +: 2];
`ifdef RO_PARITY_EN
            ep = ^ew;
`else
            ep = 1'b0;
`endif
            if (frame_done === 1'b1) fd++;
            checks++;
            if (out_en !== 1'b1 || out !== ew || ch_idx !== 3'(i/SLOT_CYC)) begin
                errors++;
                $display("FAIL frame_cycle_%0d: out_en=%b out=%0d ch=%0d want 1 %0d %0d", i, out_en, out, ch_idx, ew, i/SLOT_CYC);
            end
            checks++;
            if (out_par !== ep) begin
                errors++;
                $display("FAIL parity_cycle_%0d: out=%b out_par=%b want %b", i, out, out_par, ep);
            end
        end
        tick();
        checks++;
        if (out_en !== 1'b0 || frame_done !== 1'b1 || out !== 2'b00 || out_par !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: out_en=%b frame_done=%b out=%0d par=%b want 0 1 0 0", out_en, frame_done, out, out_par);
        end
        if (frame_done === 1'b1) fd++;
        tick();
        if (frame_done === 1'b1) fd++;
        checks++;
        if (fd != 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d want 1", fd);
        end
    endtask

    // in_bus cleared and en dropped mid-frame: frame completes from the snapshot.
    task automatic test_snapshot_en();
        logic [1:0] ew;
        snap = 16'hE4E4;
        in_bus = snap;
        clk_32 = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            clk_32 = 1'b0;
            if (i == 5) begin
                in_bus = 16'h0000;
                en = 1'b0;
            end
            ew = snap[(i/SLOT_CYC)*2 +: 2];
            checks++;
            if (out_en !== 1'b1 || out !== ew) begin
                errors++;
                $display("FAIL snapshot_cycle_%0d: out_en=%b out=%0d want 1 %0d", i, out_en, out, ew);
            end
        end
        tick();
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL snapshot_done: frame_done=%b want 1", frame_done);
        end
        en = 1'b1;
        tick();
    endtask

    task automatic test_overrun();
        logic [1:0] ew;
        snap = 16'hE4E4;
        in_bus = snap;
        clk_32 = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            clk_32 = (i == 10);
            ew = snap[(i/SLOT_CYC)*2 +: 2];
            checks++;
            if (out_en !== 1'b1 || out !== ew || ovf !== (i >= 11)) begin
                errors++;
                $display("FAIL overrun_cycle_%0d: out_en=%b out=%0d ovf=%b want 1 %0d %b", i, out_en, out, ovf, ew, i >= 11);
            end
        end
        tick();
        checks++;
        if (frame_done !== 1'b1 || ovf !== 1'b1 || out_en !== 1'b0) begin
            errors++;
            $display("FAIL overrun_end: frame_done=%b ovf=%b out_en=%b want 1 1 0", frame_done, ovf, out_en);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: ovf=%b want 0", ovf);
        end
    endtask

    // Request on the final slot edge is dropped; set beats a same-cycle clear.
    task automatic test_back_to_back();
        in_bus = 16'hE4E4;
        clk_32 = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            clk_32 = (i == FRAME - 1);
            clr_ovf = (i == FRAME - 1);
        end
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || out_en !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: frame_done=%b out_en=%b ovf=%b want 1 0 1", frame_done, out_en, ovf);
        end
        repeat (3) tick();
        checks++;
        if (out_en !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_restart: out_en=%b ovf=%b want 0 1", out_en, ovf);
        end
        clk_32 = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    // Reset at frame cycle 13 with clk_32 high through release.
    task automatic test_reset_mid();
        int bad;
        bad = 0;
        in_bus = 16'hE4E4;
        clk_32 = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            tick();
            clk_32 = (i == 3);
        end
        checks++;
        if (ovf !== 1'b1 || out_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: ovf=%b out_en=%b want 1 1", ovf, out_en);
        end
        rst = 1'b1;
        clk_32 = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_en !== 1'b0 || ch_idx !== 3'd0 || ovf !== 1'b0 || out !== 2'b00 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: out_en=%b ch=%0d ovf=%b out=%0d fd=%b want 0 0 0 0 0", out_en, ch_idx, ovf, out, frame_done);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_done !== 1'b0 || out_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d active cycles want 0", bad);
        end
        clk_32 = 1'b0;
        tick();
    endtask

    task automatic test_en_off();
        int bad;
        bad = 0;
        en = 1'b0;
        clk_32 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_en !== 1'b0 || ovf !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_off: %0d cycles with out_en or ovf set want 0", bad);
        end
        clk_32 = 1'b0;
        en = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_snapshot_en();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_en_off();
        test_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
